// File: rtl/hsync_pkg.sv
// hsync_pkg: shared horizontal timing constants, widths and receiver states
package hsync_pkg;

    localparam int POS_W  = 11;
    localparam int ADDR_W = 7;

    localparam int DEF_LINE_CYCLES = 1600;
    localparam int DEF_SYNC_CYCLES = 192;
    localparam int DEF_ADDR_START  = 288;
    localparam int DEF_DIV         = 6;

    typedef enum logic [1:0] {HUNT, TRACK, LOCKED} hsync_state_t;

    function automatic logic in_tol(int a, int b, int t);
        return (a > b ? a - b : b - a) <= t;
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// sync_2ff: two-stage synchronizer with a selectable reset value
module sync_2ff #(
    parameter logic RST_VAL = 1'b1
) (
    input  logic clk,
    input  logic reset,
    input  logic d,
    output logic q
);

    logic meta;

    // shift the asynchronous input through two flops
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) {q, meta} <= {RST_VAL, RST_VAL};
        else        {q, meta} <= {meta, d};
    end

endmodule

// File: rtl/hsync_receiver.sv
// hsync_receiver: measures an incoming hsync, locks to it and regenerates haddr/pixel_en
module hsync_receiver
    import hsync_pkg::*;
#(
    parameter int LINE_CYCLES   = DEF_LINE_CYCLES,
    parameter int SYNC_CYCLES   = DEF_SYNC_CYCLES,
    parameter int TOL           = 2,
    parameter int LOCK_LINES    = 4,
    parameter int ADDR_START    = DEF_ADDR_START,
    parameter int DIV           = DEF_DIV,
    parameter int ACTIVE_PIXELS = 128
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              hsync_in,
    output logic              locked,
    output logic              line_start,
    output logic [ADDR_W-1:0] haddr,
    output logic              pixel_en,
    output logic [POS_W-1:0]  sync_width,
    output logic [POS_W-1:0]  line_len,
    output logic              err
);

    localparam int DW      = $clog2(DIV);
    localparam int WIN_END = ADDR_START + DIV * ACTIVE_PIXELS;
    localparam logic [POS_W-1:0] POS_MAX = '1;

    logic             hs_sync, hs_prev, fall, rise, good, timeout, err_nxt;
    logic [POS_W-1:0] pos, pos_nxt;
    logic [2:0]       good_cnt, good_nxt;
    logic [DW-1:0]    div_cnt;
    hsync_state_t     state, state_nxt;

    sync_2ff #(.RST_VAL(1'b1)) u_sync (
        .clk   (clk),
        .reset (reset),
        .d     (hsync_in),
        .q     (hs_sync)
    );

    // registered edge detection on the synchronized sync
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            hs_prev <= 1'b1;
            fall    <= 1'b0;
            rise    <= 1'b0;
        end else begin
            hs_prev <= hs_sync;
            fall    <= hs_prev & ~hs_sync;
            rise    <= ~hs_prev & hs_sync;
        end
    end

    // line position, line quality and lock state transitions
    always_comb begin
        pos_nxt   = fall ? '0 : (pos == POS_MAX && !rise) ? pos : pos + 1'b1;
        good      = in_tol(int'(pos) + 1, LINE_CYCLES, TOL) && in_tol(int'(sync_width), SYNC_CYCLES, TOL);
        timeout   = pos == POS_MAX && !fall && !rise;
        state_nxt = state;
        good_nxt  = good_cnt;
        err_nxt   = 1'b0;
        if (timeout) begin
            state_nxt = HUNT;
        end else if (fall) begin
            if (state == HUNT) begin
                state_nxt = TRACK;
                good_nxt  = '0;
            end else if (!good) begin
                state_nxt = TRACK;
                good_nxt  = '0;
                err_nxt   = 1'b1;
            end else if (state == TRACK) begin
                good_nxt  = good_cnt + 3'd1;
                state_nxt = (good_cnt + 3'd1 == 3'(LOCK_LINES)) ? LOCKED : TRACK;
            end
        end
    end

    // measurement capture and state register; the width includes the falling-edge cycle
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pos        <= '0;
            state      <= HUNT;
            good_cnt   <= '0;
            locked     <= 1'b0;
            line_start <= 1'b0;
            err        <= 1'b0;
            sync_width <= '0;
            line_len   <= '0;
        end else begin
            pos        <= pos_nxt;
            state      <= state_nxt;
            good_cnt   <= good_nxt;
            locked     <= state_nxt == LOCKED;
            line_start <= fall;
            err        <= err_nxt;
            if (rise) sync_width <= pos + 1'b1;
            if (fall && state != HUNT) line_len <= pos + 1'b1;
        end
    end

    // pixel window aligned to the next position value so haddr tracks pos directly
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pixel_en <= 1'b0;
            haddr    <= '0;
            div_cnt  <= '0;
        end else if (fall || state != LOCKED || pos_nxt == POS_W'(WIN_END)) begin
            pixel_en <= 1'b0;
            haddr    <= '0;
            div_cnt  <= '0;
        end else if (pos_nxt == POS_W'(ADDR_START)) begin
            pixel_en <= 1'b1;
            haddr    <= '0;
            div_cnt  <= '0;
        end else if (pixel_en) begin
            div_cnt <= (div_cnt == DW'(DIV - 1)) ? '0 : div_cnt + 1'b1;
            if (div_cnt == DW'(DIV - 1)) haddr <= haddr + 1'b1;
        end
    end

endmodule

// File: tb/tb_hsync_receiver.sv
// tb_hsync_receiver: directed hsync streams with a queued per-line scoreboard
module tb_hsync_receiver;
    import hsync_pkg::*;

    typedef struct {
        logic lk;
        logic er;
        int   len;
        int   sw;
        logic pix;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        hsync_in = 1'b1;
    logic        locked, line_start, pixel_en, err;
    logic [6:0]  haddr;
    logic [10:0] sync_width, line_len;

    exp_t q[$];
    int   vectors = 0;
    int   fails = 0;
    int   tb_pos = 0;
    logic pix_on = 1'b0;

    hsync_receiver dut (
        .clk        (clk),
        .reset      (reset),
        .hsync_in   (hsync_in),
        .locked     (locked),
        .line_start (line_start),
        .haddr      (haddr),
        .pixel_en   (pixel_en),
        .sync_width (sync_width),
        .line_len   (line_len),
        .err        (err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        vectors++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // one line: sync low for 'low' clocks, period 'per'; expectation is for the falling edge that starts it
    task automatic send_line(input int low, input int per, input logic lk, input logic er,
                             input int len, input int sw, input logic pix);
        exp_t e;
        e.lk = lk; e.er = er; e.len = len; e.sw = sw; e.pix = pix;
        q.push_back(e);
        for (int i = 0; i < per; i++) begin
            @(negedge clk);
            hsync_in = (i >= low);
        end
    endtask

    // monitor: pops one expectation per line_start, tracks pos and checks the pixel window
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (line_start) begin
                tb_pos = 0;
                if (q.size() == 0) begin
                    vectors++;
                    fails++;
                    $display("FAIL line_start: pulse with no vector queued");
                end else begin
                    e = q.pop_front();
                    chk("locked@line", int'(locked), int'(e.lk));
                    chk("err@line", int'(err), int'(e.er));
                    chk("line_len", int'(line_len), e.len);
                    chk("sync_width", int'(sync_width), e.sw);
                    pix_on = e.pix;
                end
            end else begin
                tb_pos++;
                if (err) begin
                    vectors++;
                    fails++;
                    $display("FAIL stray_err: err=1 at pos %0d expected 0", tb_pos);
                end
            end
            if (pix_on) begin
                if (tb_pos == 287) chk("pix287_en", int'(pixel_en), 0);
                if (tb_pos == 288) chk("pix288_en", int'(pixel_en), 1);
                if (tb_pos == 288) chk("pix288_addr", int'(haddr), 0);
                if (tb_pos == 294) chk("pix294_addr", int'(haddr), 1);
                if (tb_pos == 1055) chk("pix1055_addr", int'(haddr), 127);
                if (tb_pos == 1055) chk("pix1055_en", int'(pixel_en), 1);
                if (tb_pos == 1056) chk("pix1056_en", int'(pixel_en), 0);
                if (tb_pos == 1056) begin
                    chk("pix1056_addr", int'(haddr), 0);
                    pix_on = 1'b0;
                end
            end
        end
    end

    initial begin
        int n;
        repeat (4) @(negedge clk);
        chk("rst_outputs", int'({locked, line_start, haddr, pixel_en, sync_width, line_len, err}), 0);
        reset = 1'b1;
        repeat (10) @(negedge clk);

        // acquisition from reset: HUNT->TRACK, then four good lines to lock
        send_line(192, 1600, 0, 0, 0, 0, 0);
        for (int i = 0; i < 3; i++) send_line(192, 1600, 0, 0, 1600, 192, 0);
        send_line(192, 1600, 1, 0, 1600, 192, 0);
        send_line(192, 1600, 1, 0, 1600, 192, 1);

        // in-tolerance deviations keep lock
        send_line(190, 1602, 1, 0, 1600, 192, 0);
        send_line(192, 1610, 1, 0, 1602, 190, 0);

        // out-of-tolerance line drops lock, then relock after four good lines
        send_line(192, 1600, 0, 1, 1610, 192, 0);
        for (int i = 0; i < 3; i++) send_line(192, 1600, 0, 0, 1600, 192, 0);
        send_line(192, 1600, 1, 0, 1600, 192, 0);

        // sync disappears: lock lost when pos saturates
        send_line(192, 1600, 1, 0, 1600, 192, 0);
        n = 0;
        while (locked && n < 3000) begin
            @(negedge clk);
            n++;
        end
        chk("timeout_locked", int'(locked), 0);
        chk("timeout_pos", tb_pos, 2048);
        chk("timeout_state", int'(dut.state), int'(HUNT));

        // reacquire from HUNT; line_len holds its last captured value
        send_line(192, 1600, 0, 0, 1600, 192, 0);
        for (int i = 0; i < 3; i++) send_line(192, 1600, 0, 0, 1600, 192, 0);
        send_line(192, 1600, 1, 0, 1600, 192, 0);

        // asynchronous reset around pos 500 of a locked line
        send_line(192, 500, 1, 0, 1600, 192, 0);
        chk("pre_rst_locked", int'(locked), 1);
        chk("pre_rst_pixel_en", int'(pixel_en), 1);
        #2 reset = 1'b0;
        #1;
        chk("midrst_locked", int'(locked), 0);
        chk("midrst_haddr", int'(haddr), 0);
        chk("midrst_pixel_en", int'(pixel_en), 0);
        chk("midrst_sync_width", int'(sync_width), 0);
        chk("midrst_line_len", int'(line_len), 0);
        chk("midrst_pulses", int'({line_start, err}), 0);
        repeat (3) @(negedge clk);
        reset = 1'b1;
        repeat (20) @(negedge clk);

        // lock again after five falling edges
        send_line(192, 1600, 0, 0, 0, 0, 0);
        for (int i = 0; i < 3; i++) send_line(192, 1600, 0, 0, 1600, 192, 0);
        send_line(192, 1600, 1, 0, 1600, 192, 0);

        repeat (10) @(negedge clk);
        chk("queue_drained", q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
        $finish;
    end

endmodule
